// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS load/store port: accepts one request, inserts
// WAIT_CYCLES wait states, then strobes mem_ready. `define MIPS_DMEM_BYTE_LANE_EN adds mem_be byte enables.
module mips_dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
`ifdef MIPS_DMEM_BYTE_LANE_EN
  input  logic [3:0]  mem_be,
`endif
  output logic        mem_ready,
  output logic        mem_err,
  output logic [31:0] mem_rdata,
  output logic        mem_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [31:0]         mem_q [2**ADDR_W];

  logic                accept, enter_resp, acc_we, acc_bad, mem_wr, mem_rd;
  logic [ADDR_W+1:0]   acc_addr;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_wdata;
  logic [3:0]          acc_be, cap_be;

  // Upper byte-address bits only alias the array, so they are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:ADDR_W+2];

  // Full-word accesses must be word aligned; partial-lane stores pick their lanes via be.
  function automatic logic misaligned(input logic [1:0] low, input logic [3:0] be);
    return (be == 4'hF) && (low != 2'b00);
  endfunction

`ifdef MIPS_DMEM_BYTE_LANE_EN
  logic [3:0] be_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       be_q <= 4'hF;
    else if (accept) be_q <= mem_be;
  end
  assign cap_be = be_q;
  assign acc_be = accept ? mem_be : be_q;
`else
  assign cap_be = 4'hF;
  assign acc_be = 4'hF;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      S_IDLE: if (mem_req) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_WAIT) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accept edge, so use the live inputs there.
  assign accept     = (state_q == S_IDLE) && mem_req;
  assign enter_resp = (state_d == S_RESP);
  assign acc_we     = accept ? mem_we : we_q;
  assign acc_addr   = accept ? mem_addr[ADDR_W+1:0] : addr_q;
  assign acc_wdata  = accept ? mem_wdata : wdata_q;
  assign acc_idx    = acc_addr[ADDR_W+1:2];
  assign acc_bad    = misaligned(acc_addr[1:0], acc_be);
  assign mem_wr     = enter_resp && acc_we && !acc_bad && !reset;
  assign mem_rd     = enter_resp && !acc_we;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= mem_we;
        addr_q  <= mem_addr[ADDR_W+1:0];
        wdata_q <= mem_wdata;
      end
      if (mem_rd) rdata_q <= acc_bad ? 32'h0 : mem_q[acc_idx];
    end
  end

  // NOTE: the word array has no reset; clearing it would forbid RAM inference and is not needed.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // Output logic
  always_comb begin
    mem_busy  = (state_q != S_IDLE);
    mem_ready = (state_q == S_RESP);
    mem_err   = mem_ready && misaligned(addr_q[1:0], cap_be);
    mem_rdata = rdata_q;
  end

endmodule
